// File: rtl/jtframe_pllseq_pkg.sv
// Shared types and helpers for the PLL reset/lock sequencer.
package jtframe_pllseq_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    PRST   = 3'd0,
    WAIT   = 3'd1,
    STABLE = 3'd2,
    STAGE  = 3'd3,
    RUN    = 3'd4
  } pllseq_state_e;

  // Counter only ever needs to reach max-1, so clog2(max) bits suffice; floor at 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/jtframe_sync2.sv
// Generic two-flop synchroniser with asynchronous active-low clear.
module jtframe_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      q      <= '0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/jtframe_pll_rstseq.sv
// PLL reset/lock sequencer: re-arms the PLL, waits for stable lock, then staggers
// SDRAM and game reset release. Optional lock watchdog: JTFRAME_PLL_WDOG_EN.
module jtframe_pll_rstseq
  import jtframe_pllseq_pkg::*;
#(
  parameter int PLLRST_CYC = 16,
  parameter int LOCK_CYC   = 1024,
  parameter int STAGE_GAP  = 256,
  parameter int TIMEOUT    = 65536
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               rst_sdram,
  output logic               rst_game,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retries
);

`ifdef JTFRAME_PLL_WDOG_EN
  localparam int CNT_W = cnt_width(PLLRST_CYC, LOCK_CYC, STAGE_GAP, TIMEOUT);
`else
  localparam int CNT_W = cnt_width(PLLRST_CYC, LOCK_CYC, STAGE_GAP, 1);
`endif

  localparam logic [CNT_W-1:0] PRST_LAST  = CNT_W'(PLLRST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
`ifdef JTFRAME_PLL_WDOG_EN
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
`endif

  if (PLLRST_CYC < 1 || LOCK_CYC < 1 || STAGE_GAP < 1 || TIMEOUT < 2) begin : g_bad_param
    $error("jtframe_pll_rstseq: parameter out of range");
  end

  pllseq_state_e    state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             locked_s;

  jtframe_sync2 #(.W(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= PRST;
      cnt_r     <= '0;
      pll_rst   <= 1'b1;
      rst_sdram <= 1'b1;
      rst_game  <= 1'b1;
      lock_lost <= 1'b0;
      retries   <= '0;
    end else begin
      case (state_r)
        PRST: begin
          if (cnt_r == PRST_LAST) begin
            state_r <= WAIT;
            cnt_r   <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        WAIT: begin
          if (locked_s) begin
            state_r <= STABLE;
            cnt_r   <= '0;
          end else begin
`ifdef JTFRAME_PLL_WDOG_EN
            if (cnt_r == TO_LAST) begin
              state_r <= PRST;
              cnt_r   <= '0;
              pll_rst <= 1'b1;
              if (retries != {RETRY_W{1'b1}}) begin
                retries <= retries + RETRY_W'(1);
              end else begin
                retries <= retries;
              end
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
`else
            cnt_r <= cnt_r;
`endif
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_r <= WAIT;
            cnt_r   <= '0;
          end else if (cnt_r == LOCK_LAST) begin
            state_r   <= STAGE;
            cnt_r     <= '0;
            rst_sdram <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        STAGE, RUN: begin
          // Lock dropped after SDRAM was running: reset everything and re-arm the PLL.
          if (!locked_s) begin
            state_r   <= PRST;
            cnt_r     <= '0;
            pll_rst   <= 1'b1;
            rst_sdram <= 1'b1;
            rst_game  <= 1'b1;
            lock_lost <= 1'b1;
          end else if (state_r == STAGE) begin
            if (cnt_r == GAP_LAST) begin
              state_r  <= RUN;
              cnt_r    <= '0;
              rst_game <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r   <= PRST;
          cnt_r     <= '0;
          pll_rst   <= 1'b1;
          rst_sdram <= 1'b1;
          rst_game  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_pll_rstseq.sv
// Directed self-checking bench for jtframe_pll_rstseq (PLLRST_CYC=4, LOCK_CYC=8, STAGE_GAP=4, TIMEOUT=64).
module tb_jtframe_pll_rstseq;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       rst_sdram;
  logic       rst_game;
  logic       lock_lost;
  logic [3:0] retries;

  int total = 0;
  int bad   = 0;

  jtframe_pll_rstseq #(
    .PLLRST_CYC (4),
    .LOCK_CYC   (8),
    .STAGE_GAP  (4),
    .TIMEOUT    (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .rst_sdram  (rst_sdram),
    .rst_game   (rst_game),
    .lock_lost  (lock_lost),
    .retries    (retries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pll_rst"},   32'(pll_rst),   32'd1);
    chk({tag, ".rst_sdram"}, 32'(rst_sdram), 32'd1);
    chk({tag, ".rst_game"},  32'(rst_game),  32'd1);
    chk({tag, ".lock_lost"}, 32'(lock_lost), 32'd0);
    chk({tag, ".retries"},   32'(retries),   32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    tick(3);
    chk_reset_vals("reset");

    // Cold start: pll_rst high edges 1..3, low from edge 4.
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk("cold.pll_rst",   32'(pll_rst),   (k < 4) ? 32'd1 : 32'd0);
      chk("cold.rst_sdram", 32'(rst_sdram), 32'd1);
      chk("cold.rst_game",  32'(rst_game),  32'd1);
    end

    // Glitch in STABLE: lock lost for edges 7,8; STABLE re-entered at 11.
    pll_locked = 1'b1;
    for (int k = 0; k <= 23; k++) begin
      tick(1);
      chk("glitch.rst_sdram", 32'(rst_sdram), (k >= 19) ? 32'd0 : 32'd1);
      chk("glitch.rst_game",  32'(rst_game),  (k >= 23) ? 32'd0 : 32'd1);
      chk("glitch.pll_rst",   32'(pll_rst),   32'd0);
      chk("glitch.lock_lost", 32'(lock_lost), 32'd0);
      if (k == 6) pll_locked = 1'b0;
      if (k == 8) pll_locked = 1'b1;
    end

    // Loss in RUN: detected two edges after the sync delay.
    pll_locked = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      chk("loss.rst_sdram", 32'(rst_sdram), (k >= 3) ? 32'd1 : 32'd0);
      chk("loss.rst_game",  32'(rst_game),  (k >= 3) ? 32'd1 : 32'd0);
      chk("loss.lock_lost", 32'(lock_lost), (k >= 3) ? 32'd1 : 32'd0);
      chk("loss.pll_rst",   32'(pll_rst),   (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
    end

    // Clean relock from WAIT: sdram at edge 10, game at edge 14; lock_lost sticky.
    pll_locked = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      tick(1);
      chk("lock.rst_sdram", 32'(rst_sdram), (k >= 10) ? 32'd0 : 32'd1);
      chk("lock.rst_game",  32'(rst_game),  (k >= 14) ? 32'd0 : 32'd1);
      chk("lock.lock_lost", 32'(lock_lost), 32'd1);
      chk("lock.pll_rst",   32'(pll_rst),   32'd0);
    end

    // Async reset mid-STAGE, without any clock edge.
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    #1;
    chk_reset_vals("rst_clears");
    tick(2);
    rst_n = 1'b1;
    tick(4);
    pll_locked = 1'b1;
    tick(13);
    chk("stage.rst_sdram", 32'(rst_sdram), 32'd0);
    chk("stage.rst_game",  32'(rst_game),  32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");

    // Watchdog: never lock.
    pll_locked = 1'b0;
    tick(2);
    rst_n = 1'b1;
`ifdef JTFRAME_PLL_WDOG_EN
    for (int e = 1; e <= 21 * 68; e++) begin
      int ph;
      int nto;
      tick(1);
      ph  = e % 68;
      nto = e / 68;
      chk("wdog.pll_rst", 32'(pll_rst),
          ((ph >= 1 && ph <= 3) || (ph == 0 && e >= 68)) ? 32'd1 : 32'd0);
      chk("wdog.retries", 32'(retries), (nto > 15) ? 32'd15 : 32'(nto));
    end
`else
    for (int e = 1; e <= 300; e++) begin
      tick(1);
      chk("nowdog.pll_rst", 32'(pll_rst), (e < 4) ? 32'd1 : 32'd0);
      chk("nowdog.retries", 32'(retries), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
